ex_mdu: RTL and testbench

EX_MDU -- requirements
Module: ex_mdu

---
 rtl/ex_mdu_if.sv | 26 ++
 rtl/ex_mdu.sv | 155 +++++++++++++++
 tb/tb_ex_mdu.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mdu_if.sv
// Request/write-back bundle between the execute stage and the ex_mdu multiply/divide unit.
interface ex_mdu_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
);
  logic               start_i;
  logic [2:0]         op_i;
  logic [XLEN-1:0]    op_num1_i;
  logic [XLEN-1:0]    op_num2_i;
  logic [RADDR_W-1:0] rd_addr_i;
  logic               flush_i;
  logic [RADDR_W-1:0] rd_addr_o;
  logic [XLEN-1:0]    rd_data_o;
  logic               rd_wen_o;
  logic               hold_flag_o;

  modport master (
    output start_i, op_i, op_num1_i, op_num2_i, rd_addr_i, flush_i,
    input  rd_addr_o, rd_data_o, rd_wen_o, hold_flag_o
  );

  modport slave (
    input  start_i, op_i, op_num1_i, op_num2_i, rd_addr_i, flush_i,
    output rd_addr_o, rd_data_o, rd_wen_o, hold_flag_o
  );
endinterface

// File: rtl/ex_mdu.sv
// Radix-2 iterative RV M-extension multiply/divide unit (IDLE -> CALC -> DONE).
// Define MDU_FAST_MUL_EN to compute multiplies in a single cycle; divides always iterate.
module ex_mdu #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input logic     clk,
  input logic     rst,
  ex_mdu_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_next;

  logic [2:0]         op_q;
  logic [XLEN-1:0]    mcand_q;
  logic [XLEN-1:0]    hi_q;
  logic [XLEN-1:0]    lo_q;
  logic [RADDR_W-1:0] rd_addr_q;
  logic               neg_q;
  logic [CNT_W-1:0]   cnt_q;

  logic            is_div, a_signed, b_signed, sign_a, sign_b;
  logic            div_zero, div_ovf, fast, neg, accept;
  logic [XLEN-1:0] abs_a, abs_b;

  // Operands are reduced to magnitudes up front; the sign is reapplied on the way out.
  always_comb begin
    is_div   = bus.op_i[2];
    a_signed = is_div ? !bus.op_i[0] : (bus.op_i[1:0] != 2'b11);
    b_signed = is_div ? !bus.op_i[0] : !bus.op_i[1];
    sign_a   = a_signed && bus.op_num1_i[XLEN-1];
    sign_b   = b_signed && bus.op_num2_i[XLEN-1];
    abs_a    = sign_a ? -bus.op_num1_i : bus.op_num1_i;
    abs_b    = sign_b ? -bus.op_num2_i : bus.op_num2_i;
    neg      = (is_div && bus.op_i[1]) ? sign_a : (sign_a ^ sign_b);
    div_zero = is_div && (bus.op_num2_i == '0);
    div_ovf  = is_div && !bus.op_i[0] && (bus.op_num1_i == {1'b1, {(XLEN-1){1'b0}}})
               && (bus.op_num2_i == '1);
`ifdef MDU_FAST_MUL_EN
    fast     = div_zero || div_ovf || !is_div;
`else
    fast     = div_zero || div_ovf;
`endif
    accept   = (state == IDLE) && bus.start_i && !bus.flush_i;
  end

  logic [XLEN:0] add_sum, shifted, diff;

  always_comb begin
    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, mcand_q};
  end

  // hi/lo hold the partial product, or remainder/quotient during a divide.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      rd_addr_q <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
    end else if (accept) begin
      op_q      <= bus.op_i;
      rd_addr_q <= bus.rd_addr_i;
      cnt_q     <= CNT_W'(XLEN);
      mcand_q   <= is_div ? abs_b : abs_a;
      if (div_zero) begin
        hi_q  <= bus.op_num1_i;
        lo_q  <= '1;
        neg_q <= 1'b0;
      end else if (div_ovf) begin
        hi_q  <= '0;
        lo_q  <= bus.op_num1_i;
        neg_q <= 1'b0;
`ifdef MDU_FAST_MUL_EN
      end else if (!is_div) begin
        {hi_q, lo_q} <= {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
        neg_q        <= neg;
`endif
      end else begin
        hi_q  <= '0;
        lo_q  <= is_div ? abs_a : abs_b;
        neg_q <= neg;
      end
    end else if (state == CALC) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (op_q[2]) begin
        if (!diff[XLEN]) begin
          hi_q <= diff[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_q <= shifted[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        hi_q <= add_sum[XLEN:1];
        lo_q <= {add_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   result;

  always_comb begin
    prod = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    case (op_q)
      3'b000:                 result = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result = neg_q ? -lo_q : lo_q;
      default:                result = neg_q ? -hi_q : hi_q;
    endcase
  end

  // A flush in DONE suppresses the write-back of the operation being retired.
  always_comb begin
    state_next      = state;
    bus.hold_flag_o = 1'b0;
    bus.rd_wen_o    = 1'b0;
    bus.rd_addr_o   = '0;
    bus.rd_data_o   = '0;
    case (state)
      IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          bus.hold_flag_o = 1'b1;
          state_next      = fast ? DONE : CALC;
        end
      end
      CALC: begin
        bus.hold_flag_o = 1'b1;
        if (cnt_q == CNT_W'(1)) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
        if (!bus.flush_i) begin
          bus.rd_wen_o  = 1'b1;
          bus.rd_addr_o = rd_addr_q;
          bus.rd_data_o = result;
        end
      end
      default: state_next = IDLE;
    endcase
    if (bus.flush_i) state_next = IDLE;
  end
endmodule

// File: tb/tb_ex_mdu.sv
// Directed testbench for ex_mdu: a transaction-level model predicts every cycle's outputs,
// and each directed vector also carries hand-computed result and latency values.
module tb_ex_mdu;
  localparam int XLEN     = 32;
  localparam int RADDR_W  = 5;
  localparam int ITER_LAT = XLEN + 1;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = ITER_LAT;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_mdu_if #(.XLEN(XLEN), .RADDR_W(RADDR_W)) bus ();
  ex_mdu #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      if (n_fail <= 40)
        $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    logic [63:0]        p;
    logic signed [31:0] sa, sb, r;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b};       return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b};             return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        r = sa / sb;
        return r;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        r = sa % sb;
        return r;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    if (op[2]) begin
      if (b == 0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return ITER_LAT;
    end
    return MUL_LAT;
  endfunction

  // Model: one outstanding operation, retired at a known cycle; reset or flush discards it.
  int          cyc = 0;
  bit          pend = 1'b0;
  int          done_cyc = 0;
  logic [31:0] exp_data = '0;
  logic [4:0]  exp_addr = '0;
  logic        exp_wen, exp_hold;

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      exp_wen  = pend && (cyc == done_cyc) && !bus.flush_i;
      exp_hold = (!pend && bus.start_i && !bus.flush_i) || (pend && cyc < done_cyc);
      checkOutput($sformatf("rd_wen@%0d", cyc), bus.rd_wen_o, exp_wen);
      checkOutput($sformatf("hold@%0d", cyc), bus.hold_flag_o, exp_hold);
      checkOutput($sformatf("rd_addr@%0d", cyc), bus.rd_addr_o, exp_wen ? exp_addr : 5'd0);
      checkOutput($sformatf("rd_data@%0d", cyc), bus.rd_data_o, exp_wen ? exp_data : 32'd0);
    end
    if (rst || bus.flush_i) pend = 1'b0;
    else if (pend) begin
      if (cyc == done_cyc) pend = 1'b0;
    end else if (bus.start_i) begin
      pend     = 1'b1;
      done_cyc = cyc + model_latency(bus.op_i, bus.op_num1_i, bus.op_num2_i);
      exp_data = model_result(bus.op_i, bus.op_num1_i, bus.op_num2_i);
      exp_addr = bus.rd_addr_i;
    end
  end

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] addr, output bit found, output int lat,
                               output int hold_cnt, output logic [31:0] data);
    @(posedge clk); #1;
    bus.start_i   = 1'b1;
    bus.op_i      = op;
    bus.op_num1_i = a;
    bus.op_num2_i = b;
    bus.rd_addr_i = addr;
    found    = 1'b0;
    lat      = -1;
    hold_cnt = 0;
    data     = '0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (bus.rd_wen_o === 1'b1) begin
        found = 1'b1;
        lat   = k;
        data  = bus.rd_data_o;
      end else begin
        if (bus.hold_flag_o === 1'b1) hold_cnt++;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
      end
    end
  endtask

  task automatic runVector(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] addr,
                           input logic [31:0] exp, input int exp_lat);
    bit          found;
    int          lat, hold_cnt;
    logic [31:0] data;
    applyStimulus(op, a, b, addr, found, lat, hold_cnt, data);
    if (!found) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s_timeout: got no rd_wen_o within 60 cycles, expected one", name);
    end else begin
      checkOutput({name, "_data"}, data, exp);
      checkOutput({name, "_latency"}, lat, exp_lat);
      checkOutput({name, "_hold_cycles"}, hold_cnt, exp_lat);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int   wen_cnt;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.start_i   = 1'b0;
    bus.op_i      = '0;
    bus.op_num1_i = '0;
    bus.op_num2_i = '0;
    bus.rd_addr_i = '0;
    bus.flush_i   = 1'b0;

    vecs.push_back(vec_t'{3'd5, 32'd100,        32'd7,          32'd14,         ITER_LAT});
    vecs.push_back(vec_t'{3'd7, 32'd100,        32'd7,          32'd2,          ITER_LAT});
    vecs.push_back(vec_t'{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  ITER_LAT});
    vecs.push_back(vec_t'{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  ITER_LAT});
    vecs.push_back(vec_t'{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF,  1});
    vecs.push_back(vec_t'{3'd6, 32'd5,          32'd0,          32'd5,          1});
    vecs.push_back(vec_t'{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
    vecs.push_back(vec_t'{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1});
    vecs.push_back(vec_t'{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  MUL_LAT});
    vecs.push_back(vec_t'{3'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  MUL_LAT});
    vecs.push_back(vec_t'{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000,  MUL_LAT});
    vecs.push_back(vec_t'{3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  MUL_LAT});
    vecs.push_back(vec_t'{3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  MUL_LAT});
    vecs.push_back(vec_t'{3'd3, 32'h0001_0000,  32'h0001_0000,  32'h0000_0001,  MUL_LAT});
    vecs.push_back(vec_t'{3'd0, 32'd3,          32'hFFFF_FFFB,  32'hFFFF_FFF1,  MUL_LAT});
    vecs.push_back(vec_t'{3'd1, 32'd3,          32'hFFFF_FFFB,  32'hFFFF_FFFF,  MUL_LAT});
    vecs.push_back(vec_t'{3'd4, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  ITER_LAT});
    vecs.push_back(vec_t'{3'd6, 32'd7,          32'hFFFF_FFFE,  32'd1,          ITER_LAT});
    vecs.push_back(vec_t'{3'd4, 32'hFFFF_FFF8,  32'hFFFF_FFFE,  32'd4,          ITER_LAT});
    vecs.push_back(vec_t'{3'd5, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  ITER_LAT});
    vecs.push_back(vec_t'{3'd7, 32'hFFFF_FFFF,  32'h10,         32'hF,          ITER_LAT});

    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_wen", bus.rd_wen_o, 1'b0);
    checkOutput("reset_hold", bus.hold_flag_o, 1'b0);
    checkOutput("reset_data", bus.rd_data_o, 32'd0);

    foreach (vecs[i])
      runVector($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1),
                vecs[i].exp, vecs[i].lat);

    // start together with flush must not be accepted
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.flush_i = 1'b1;
    bus.op_i = 3'd5; bus.op_num1_i = 32'd50; bus.op_num2_i = 32'd5; bus.rd_addr_i = 5'd3;
    @(negedge clk);
    checkOutput("start_with_flush_hold", bus.hold_flag_o, 1'b0);
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    @(negedge clk);
    checkOutput("start_with_flush_idle", bus.hold_flag_o, 1'b0);

    // flush at CALC cycle 10
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.op_i = 3'd5;
    bus.op_num1_i = 32'd1000; bus.op_num2_i = 32'd3; bus.rd_addr_i = 5'd17;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.flush_i = 1'b1;
    @(negedge clk);
    checkOutput("flush_cycle_hold", bus.hold_flag_o, 1'b1);
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    @(negedge clk);
    checkOutput("after_flush_hold", bus.hold_flag_o, 1'b0);
    checkOutput("after_flush_wen", bus.rd_wen_o, 1'b0);

    // reset at CALC cycle 5
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.op_i = 3'd5;
    bus.op_num1_i = 32'd2000; bus.op_num2_i = 32'd7; bus.rd_addr_i = 5'd18;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("after_reset_hold", bus.hold_flag_o, 1'b0);
    checkOutput("after_reset_wen", bus.rd_wen_o, 1'b0);
    checkOutput("after_reset_data", bus.rd_data_o, 32'd0);
    wen_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.rd_wen_o === 1'b1) wen_cnt++;
    end
    checkOutput("aborted_ops_wen_count", wen_cnt, 0);
    runVector("divu_9_3_after_abort", 3'd5, 32'd9, 32'd3, 5'd21, 32'd3, ITER_LAT);

    // start held high: one write-back per accepted start
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.op_i = 3'd5;
    bus.op_num1_i = 32'd9; bus.op_num2_i = 32'd3; bus.rd_addr_i = 5'd9;
    wen_cnt = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (bus.rd_wen_o === 1'b1) wen_cnt++;
      @(posedge clk); #1;
    end
    bus.start_i = 1'b0;
    checkOutput("held_start_wen_count", wen_cnt, 2);
    repeat (40) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
